// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single line-wide memory port.
// Level requests become one-cycle memory strobes; completions are pulsed back and counted per port.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic              s0_read,
  input  logic              s0_write,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              s1_read,
  input  logic              s1_write,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                op_rd_q, op_rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   s0_rdata_q, s0_rdata_d;
  logic [DATA_W-1:0]   s1_rdata_q, s1_rdata_d;
  logic                s0_ready_q, s0_ready_d;
  logic                s1_ready_q, s1_ready_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d;
  logic [CNT_W-1:0]    cnt1_q, cnt1_d;
  logic [1:0]          req;
  logic                gnt;

  assign req = {s1_read | s1_write, s0_read | s0_write};

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_rd_d      = op_rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    s0_rdata_d   = s0_rdata_q;
    s1_rdata_d   = s1_rdata_q;
    s0_ready_d   = 1'b0;
    s1_ready_d   = 1'b0;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    gnt          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the port that did not win last time gets the grant.
          gnt         = (&req) ? ~last_grant_q : req[1];
          grant_d     = gnt;
          addr_d      = gnt ? s1_addr : s0_addr;
          wdata_d     = gnt ? s1_wdata : s0_wdata;
          op_rd_d     = gnt ? s1_read : s0_read;
          mem_read_d  = gnt ? s1_read : s0_read;
          mem_write_d = gnt ? ~s1_read : ~s0_read;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (op_rd_q) begin
            if (grant_q) s1_rdata_d = mem_rdata;
            else         s0_rdata_d = mem_rdata;
          end
          s0_ready_d   = ~grant_q;
          s1_ready_d   = grant_q;
          last_grant_d = grant_q;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (grant_q) begin
          if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
        end else begin
          if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_rd_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      s0_rdata_q   <= '0;
      s1_rdata_q   <= '0;
      s0_ready_q   <= 1'b0;
      s1_ready_q   <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_rd_q      <= op_rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      s0_rdata_q   <= s0_rdata_d;
      s1_rdata_q   <= s1_rdata_d;
      s0_ready_q   <= s0_ready_d;
      s1_ready_q   <= s1_ready_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign s0_rdata  = s0_rdata_q;
  assign s1_rdata  = s1_rdata_q;
  assign s0_ready  = s0_ready_q;
  assign s1_ready  = s1_ready_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two requester drivers, a 10-cycle line memory and a
// cycle-level service model (serial service, 13-cycle turnaround, round-robin on ties).
module tb_mem_arbiter;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  s0_addr, s1_addr, mem_addr;
  logic [255:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, mem_wdata, mem_rdata;
  logic         s0_read, s1_read, s0_write, s1_write, s0_ready, s1_ready;
  logic         mem_read, mem_write, mem_ready, busy;
  logic [3:0]   cnt0, cnt1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(256), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_read(s0_read), .s0_write(s0_write),
    .s0_rdata(s0_rdata), .s0_ready(s0_ready),
    .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_read(s1_read), .s1_write(s1_write),
    .s1_rdata(s1_rdata), .s1_ready(s1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 32; k++) l[8*k +: 8] = a[7:0] + 8'(k);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // Line memory: strobe sampled at a rising edge, ready pulse 11 cycles after the strobe cycle.
  logic [255:0] env_mem [16];
  logic         env_wr  [16];
  logic [3:0]   mcnt;
  logic [31:0]  m_addr;
  logic         m_rd;
  bit           spur_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      mcnt      <= 4'd0;
      for (int i = 0; i < 16; i++) env_wr[i] <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_read || mem_write) begin
        mcnt   <= 4'd10;
        m_addr <= mem_addr;
        m_rd   <= mem_read;
        if (mem_write) begin
          env_mem[mem_addr[8:5]] <= mem_wdata;
          env_wr[mem_addr[8:5]]  <= 1'b1;
        end
      end else if (mcnt != 4'd0) begin
        mcnt <= mcnt - 4'd1;
        if (mcnt == 4'd1) begin
          mem_ready <= 1'b1;
          if (m_rd) mem_rdata <= env_wr[m_addr[8:5]] ? env_mem[m_addr[8:5]] : init_line(m_addr);
          else      mem_rdata <= rand_line();
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        // Stray ready while nothing is outstanding; the arbiter must ignore it.
        mem_ready <= 1'b1;
        mem_rdata <= rand_line();
      end
    end
  end

  // Requester state and reference model.
  req_t         q0[$], q1[$];
  req_t         cur [2];
  bit           cur_v [2];
  bit           load_rand;
  bit           rst_armed;
  bit           sch_v;
  int           sch_port, sch_start, free_cyc, last_grant, cyc;
  req_t         sch_req;
  logic [255:0] gold [16];
  logic [255:0] rd_model [2];
  logic [3:0]   cnt_model [2];
  int           n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    sch_v      = 1'b0;
    free_cyc   = 0;
    last_grant = 1;
    cyc        = -1;
    for (int p = 0; p < 2; p++) begin
      rd_model[p]  = '0;
      cnt_model[p] = 4'd0;
      cur_v[p]     = 1'b0;
    end
    for (int i = 0; i < 16; i++) gold[i] = init_line(32'(i * 32));
  endtask

  task automatic drive_ports();
    s0_read  = cur_v[0] & cur[0].rd;
    s0_write = cur_v[0] & cur[0].wr;
    s0_addr  = cur[0].addr;
    s0_wdata = cur[0].wdata;
    s1_read  = cur_v[1] & cur[1].rd;
    s1_write = cur_v[1] & cur[1].wr;
    s1_addr  = cur[1].addr;
    s1_wdata = cur[1].wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) cur_v[p] = 1'b0;
    drive_ports();
    #1;
    check_eq("rst_ctl", 256'({busy, mem_read, mem_write, s1_ready, s0_ready}), 256'(0));
    check_eq("rst_cnt", 256'({cnt1, cnt0}), 256'(0));
    check_eq("rst_rdata", s0_rdata | s1_rdata, 256'(0));
    check_eq("rst_maddr", 256'(mem_addr), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step();
    logic [4:0] exp_ctl;
    bit         rdy, strobe;
    int         p;
    @(negedge clk);
    cyc++;
    strobe  = sch_v && (cyc == sch_start + 1);
    rdy     = sch_v && (cyc == sch_start + 13);
    exp_ctl = {sch_v && cyc >= sch_start + 1 && cyc <= sch_start + 13,
               strobe && sch_req.rd, strobe && !sch_req.rd,
               rdy && sch_port == 1, rdy && sch_port == 0};
    check_eq("ctl", 256'({busy, mem_read, mem_write, s1_ready, s0_ready}), 256'(exp_ctl));
    if (strobe) begin
      check_eq("mem_addr", 256'(mem_addr), 256'(sch_req.addr));
      if (!sch_req.rd) check_eq("mem_wdata", mem_wdata, sch_req.wdata);
    end
    if (rdy) begin
      if (sch_req.rd) rd_model[sch_port] = gold[sch_req.addr[8:5]];
      else            gold[sch_req.addr[8:5]] = sch_req.wdata;
      check_eq("rdata0", s0_rdata, rd_model[0]);
      check_eq("rdata1", s1_rdata, rd_model[1]);
      check_eq("cnt", 256'({cnt1, cnt0}), 256'({cnt_model[1], cnt_model[0]}));
      if (cnt_model[sch_port] != 4'hF) cnt_model[sch_port] = cnt_model[sch_port] + 4'd1;
      $display("txn port %0d %s addr %h granted cycle %0d ready cycle %0d",
               sch_port, sch_req.rd ? "rd" : "wr", sch_req.addr, sch_start, cyc);
      cur_v[sch_port] = 1'b0;
      sch_v = 1'b0;
    end
    if (rst_armed && sch_v && cyc == sch_start + 6) begin
      rst_armed = 1'b0;
      do_reset();
      q1.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h1A0, wdata: '0});
    end else begin
      if (!cur_v[0] && q0.size() != 0 && (!load_rand || $urandom_range(0, 2) != 0)) begin
        cur[0] = q0.pop_front(); cur_v[0] = 1'b1;
      end
      if (!cur_v[1] && q1.size() != 0 && (!load_rand || $urandom_range(0, 2) != 0)) begin
        cur[1] = q1.pop_front(); cur_v[1] = 1'b1;
      end
      drive_ports();
      if (!sch_v && cyc >= free_cyc && (cur_v[0] || cur_v[1])) begin
        p = (cur_v[0] && cur_v[1]) ? 1 - last_grant : (cur_v[1] ? 1 : 0);
        sch_v = 1'b1; sch_port = p; sch_start = cyc; sch_req = cur[p];
        free_cyc = cyc + 14; last_grant = p;
      end
    end
  endtask

  task automatic run_until_idle();
    int n;
    n = 0;
    while ((sch_v || cur_v[0] || cur_v[1] || q0.size() != 0 || q1.size() != 0 || rst_armed) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check_eq("timeout", 256'(1), 256'(0));
    repeat (2) step();
  endtask

  function automatic req_t mk(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] d);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = d;
    return r;
  endfunction

  initial begin
    logic [1:0] op;
    n_checks = 0; n_errors = 0;
    load_rand = 1'b0; rst_armed = 1'b0;
    for (int p = 0; p < 2; p++) cur[p] = '0;
    model_reset();
    drive_ports();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_ctl", 256'({busy, mem_read, mem_write, s1_ready, s0_ready}), 256'(0));
    check_eq("reset_cnt", 256'({cnt1, cnt0}), 256'(0));
    check_eq("reset_rdata", s0_rdata | s1_rdata, 256'(0));
    rst_n = 1'b1;

    // Single read, write then read-back, sustained contention, read+write collision.
    q0.push_back(mk(1'b1, 1'b0, 32'h40, '0));
    run_until_idle();
    q1.push_back(mk(1'b0, 1'b1, 32'h100, {32{8'hA5}}));
    q1.push_back(mk(1'b1, 1'b0, 32'h100, '0));
    run_until_idle();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b1, 1'b0, 32'(32 * i), '0));
      q1.push_back(mk(1'b1, 1'b0, 32'(32 * (i + 4)), '0));
    end
    run_until_idle();
    q0.push_back(mk(1'b1, 1'b1, 32'h60, rand_line()));
    q0.push_back(mk(1'b1, 1'b0, 32'h60, '0));
    run_until_idle();

    // Randomized traffic with stray memory ready pulses and request gaps.
    load_rand = 1'b1; spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 0) q0.push_back(mk(op[0], op[1], 32'($urandom_range(0, 15) * 32), rand_line()));
      else                           q1.push_back(mk(op[0], op[1], 32'($urandom_range(0, 15) * 32), rand_line()));
    end
    run_until_idle();
    load_rand = 1'b0;

    // Reset while a read is waiting on memory, then a fresh port 1 request.
    q0.push_back(mk(1'b1, 1'b0, 32'h80, '0));
    rst_armed = 1'b1;
    run_until_idle();

    // Counter saturation on port 0.
    for (int i = 0; i < 17; i++) q0.push_back(mk(1'b1, 1'b0, 32'($urandom_range(0, 15) * 32), '0));
    run_until_idle();
    check_eq("cnt0_sat", 256'(cnt0), 256'(4'hF));
    check_eq("cnt1_end", 256'(cnt1), 256'(cnt_model[1]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
